// File: rtl/core_pkg.sv
// Shared core definitions: default datapath widths, control-bit positions and the
// flattened payload layout carried between pipeline stages.
package core_pkg;

  localparam int XLEN      = 64;
  localparam int NLANE     = 2;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 2;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  // Field order matches the flattened vector used by the stage register: {data, rd, ctrl}
  typedef struct packed {
    logic [NLANE*XLEN-1:0] data;
    logic [REG_IDX_W-1:0]  rd;
    logic [CTRL_W-1:0]     ctrl;
  } stage_payload_t;

  localparam int STAGE_PAYLOAD_W = $bits(stage_payload_t);

  function automatic int payloadWidth(input int xlen, input int nlane, input int rdW, input int ctrlW);
    return xlen * nlane + rdW + ctrlW;
  endfunction

endpackage

// File: rtl/skid_entry.sv
// One storage slot of the elastic stage: a payload register with its valid bit.
// Load wins over clear; clear only drops the valid bit and leaves the payload as is.
module skid_entry #(
  parameter int W = core_pkg::STAGE_PAYLOAD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with a two-entry skid buffer (main M + skid S),
// stall/flush handling, bubble-safe control masking and a saturating bubble counter.
module pipe_stage_skid_reg #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int NLANE  = core_pkg::NLANE,
  parameter int RD_W   = core_pkg::REG_IDX_W,
  parameter int CTRL_W = core_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NLANE*XLEN-1:0] in_data,
  input  logic [RD_W-1:0]       in_rd,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NLANE*XLEN-1:0] out_data,
  output logic [RD_W-1:0]       out_rd,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int DATA_W = NLANE * XLEN;
  localparam int PAY_W  = core_pkg::payloadWidth(XLEN, NLANE, RD_W, CTRL_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             mValid;
  logic             sValid;
  logic [PAY_W-1:0] mQ;
  logic [PAY_W-1:0] sQ;
  logic [PAY_W-1:0] mD;
  logic [PAY_W-1:0] inPayload;
  logic             mLoad;
  logic             mClear;
  logic             sLoad;
  logic             sClear;
  logic             inFire;
  logic             outFire;
  logic [CNT_W-1:0] bubbleCount;

  assign inPayload = {in_data, in_rd, in_ctrl};

  // in_ready comes straight from the skid valid flop, so out_ready never reaches it
  assign in_ready = ~sValid;
  assign inFire   = in_valid & ~sValid & ~stall;
  assign outFire  = mValid & out_ready & ~stall;

  always_comb begin
    mLoad  = 1'b0;
    mClear = 1'b0;
    sLoad  = 1'b0;
    sClear = 1'b0;
    mD     = inPayload;
    if (flush) begin
      mClear = 1'b1;
      sClear = 1'b1;
    end else if (sValid) begin
      if (outFire) begin
        mLoad  = 1'b1;
        mD     = sQ;
        sClear = 1'b1;
      end
    end else if (mValid) begin
      if (inFire && outFire) begin
        mLoad = 1'b1;
      end else if (inFire) begin
        sLoad = 1'b1;
      end else if (outFire) begin
        mClear = 1'b1;
      end
    end else if (inFire) begin
      mLoad = 1'b1;
    end
  end

  skid_entry #(.W(PAY_W)) mEntry (
    .clk   (clk),
    .reset (reset),
    .load  (mLoad),
    .clear (mClear),
    .d     (mD),
    .valid (mValid),
    .q     (mQ)
  );

  skid_entry #(.W(PAY_W)) sEntry (
    .clk   (clk),
    .reset (reset),
    .load  (sLoad),
    .clear (sClear),
    .d     (inPayload),
    .valid (sValid),
    .q     (sQ)
  );

  // Bubbles are counted only while the stage is running; stalled cycles are not bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      bubbleCount <= '0;
    end else if (!mValid && !stall && bubbleCount != CNT_MAX) begin
      bubbleCount <= bubbleCount + 1'b1;
    end
  end

  assign out_valid  = mValid;
  assign out_data   = mQ[PAY_W-1 -: DATA_W];
  assign out_rd     = mQ[CTRL_W +: RD_W] & {RD_W{mValid}};
  assign out_ctrl   = mQ[CTRL_W-1:0] & {CTRL_W{mValid}};
  assign bubble_cnt = bubbleCount;

endmodule
